// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the iterative multiply controller.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // One extra bit so the counter can hold WIDTH itself and wrap naturally.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: operand magnitudes, 2*WIDTH accumulator,
// final sign fix-up and the result/flag holding registers.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             finish_i,
  input  logic             long_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic             flag_n_o,
  output logic             flag_z_o
);

  localparam int AW = 2 * WIDTH;

  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             neg_q;
  logic             long_q;

  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             flag_n_q;
  logic             flag_z_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [AW-1:0]    product;
  logic [WIDTH-1:0] res_lo_d;
  logic [WIDTH-1:0] res_hi_d;
  logic             flag_n_d;
  logic             flag_z_d;

  // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (signed_i && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    mag_b = (signed_i && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  end

  always_comb begin
    product  = neg_q ? -acc_q : acc_q;
    res_lo_d = product[WIDTH-1:0];
    res_hi_d = long_q ? product[AW-1:WIDTH] : '0;
    flag_n_d = long_q ? res_hi_d[WIDTH-1] : res_lo_d[WIDTH-1];
    flag_z_d = ~|{res_hi_d, res_lo_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      long_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (load_i) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
        mplier_q <= mag_b;
        neg_q    <= signed_i & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
        long_q   <= long_i;
      end else if (step_i) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (finish_i) begin
        res_lo_q <= res_lo_d;
        res_hi_q <= res_hi_d;
        flag_n_q <= flag_n_d;
        flag_z_q <= flag_z_d;
      end
    end
  end

  // Fresh values are visible during the finishing cycle, held values otherwise.
  assign res_lo_o = finish_i ? res_lo_d : res_lo_q;
  assign res_hi_o = finish_i ? res_hi_d : res_hi_q;
  assign flag_n_o = finish_i ? flag_n_d : flag_n_q;
  assign flag_z_o = finish_i ? flag_z_d : flag_z_q;

endmodule

// File: rtl/mul_sequencer.sv
// Execute-stage multiply controller: sequences the shift-add engine for
// MUL/UMULL/SMULL, stalls the front of the pipe and honours flushes.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             LongE,
  input  logic             SignedE,
  input  logic             KillE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             StallMul,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             FlagN,
  output logic             FlagZ
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic load;
  logic step;
  logic finish;
  logic stall;
  logic busy;
  logic done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    stall   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (StartE && !KillE) begin
          load    = 1'b1;
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (KillE) begin
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The still-asserted StartE belongs to this instruction; never restart here.
        state_d = ST_IDLE;
        if (!KillE) begin
          done   = 1'b1;
          finish = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (reset) begin
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      stall  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
    end
  end

  assign StallMul = stall;
  assign Busy     = busy;
  assign Done     = done;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_shift_add (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .step_i   (step),
    .finish_i (finish),
    .long_i   (LongE),
    .signed_i (SignedE),
    .src_a_i  (SrcAE),
    .src_b_i  (SrcBE),
    .res_lo_o (ResultLo),
    .res_hi_o (ResultHi),
    .flag_n_o (FlagN),
    .flag_z_o (FlagZ)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: reset, MUL/UMULL/SMULL products,
// flush in IDLE/BUSY/DONE and back-to-back instructions.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic        LongE;
  logic        SignedE;
  logic        KillE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        StallMul;
  logic        Busy;
  logic        Done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic        FlagN;
  logic        FlagZ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_sequencer #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .StartE   (StartE),
    .LongE    (LongE),
    .SignedE  (SignedE),
    .KillE    (KillE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .StallMul (StallMul),
    .Busy     (Busy),
    .Done     (Done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi),
    .FlagN    (FlagN),
    .FlagZ    (FlagZ)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ctl();
    return 64'({StallMul, Busy, Done});
  endfunction

  // Issues one multiply at the current cycle (cycle 0) and checks cycles 0..33.
  // Returns at the start of cycle 34 with StartE still high.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic lng,
                         input logic sgn, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_n, input logic exp_z, input logic kill_done,
                         input string tag);
    SrcAE   = a;
    SrcBE   = b;
    LongE   = lng;
    SignedE = sgn;
    StartE  = 1'b1;
    KillE   = 1'b0;
    @(negedge clk);
    check({tag, "_c0_ctl"}, ctl(), 64'(3'b100));
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("%s_c%0d_ctl", tag, c), ctl(), 64'(3'b110));
    end
    next_cycle();
    if (kill_done) KillE = 1'b1;
    @(negedge clk);
    check({tag, "_c33_ctl"}, ctl(), kill_done ? 64'(3'b000) : 64'(3'b001));
    check({tag, "_lo"}, 64'(ResultLo), 64'(exp_lo));
    check({tag, "_hi"}, 64'(ResultHi), 64'(exp_hi));
    check({tag, "_nz"}, 64'({FlagN, FlagZ}), 64'({exp_n, exp_z}));
    next_cycle();
    KillE = 1'b0;
  endtask

  task automatic idle_hold(input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string tag);
    StartE = 1'b0;
    @(negedge clk);
    check({tag, "_ctl"}, ctl(), 64'(3'b000));
    check({tag, "_res"}, {ResultHi, ResultLo}, {exp_hi, exp_lo});
    next_cycle();
  endtask

  initial begin
    reset   = 1'b1;
    StartE  = 1'b1;
    LongE   = 1'b1;
    SignedE = 1'b1;
    KillE   = 1'b0;
    SrcAE   = 32'd5;
    SrcBE   = 32'd7;
    for (int r = 0; r < 2; r++) begin
      next_cycle();
      @(negedge clk);
      check("rst_ctl", ctl(), 64'(3'b000));
      check("rst_res", {ResultHi, ResultLo}, 64'h0);
      check("rst_flags", 64'({FlagN, FlagZ}), 64'(2'b00));
    end
    reset  = 1'b0;
    StartE = 1'b0;
    next_cycle();
    @(negedge clk);
    check("post_rst_idle", ctl(), 64'(3'b000));
    next_cycle();

    run_mul(32'd7, 32'd6, 1'b0, 1'b0, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0, "mul_7x6");
    idle_hold(32'd42, 32'd0, "mul_7x6_hold");

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE,
            1'b1, 1'b0, 1'b0, "umull_max");
    idle_hold(32'h0000_0001, 32'hFFFF_FFFE, "umull_max_hold");

    run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF,
            1'b1, 1'b0, 1'b0, "smull_m3x5");
    idle_hold(32'hFFFF_FFF1, 32'hFFFF_FFFF, "smull_m3x5_hold");

    run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 32'h4000_0000,
            1'b0, 1'b0, 1'b0, "smull_minxmin");
    idle_hold(32'h0000_0000, 32'h4000_0000, "smull_minxmin_hold");

    run_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 32'hC000_0000,
            1'b1, 1'b0, 1'b0, "smull_maxxmin");
    idle_hold(32'h8000_0000, 32'hC000_0000, "smull_maxxmin_hold");

    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0,
            1'b1, 1'b0, 1'b0, "mul_neglo");
    idle_hold(32'hFFFF_FFFE, 32'd0, "mul_neglo_hold");

    // Flush during DONE: no pulse, previous results stay.
    run_mul(32'd5, 32'd5, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0, 1'b1, "kill_done");
    idle_hold(32'hFFFF_FFFE, 32'd0, "kill_done_hold");

    // Flush in IDLE: start refused.
    SrcAE  = 32'd3;
    SrcBE  = 32'd4;
    LongE  = 1'b0;
    SignedE = 1'b0;
    StartE = 1'b1;
    KillE  = 1'b1;
    @(negedge clk);
    check("kill_idle_c0", ctl(), 64'(3'b000));
    next_cycle();
    StartE = 1'b0;
    KillE  = 1'b0;
    @(negedge clk);
    check("kill_idle_c1", ctl(), 64'(3'b000));
    next_cycle();

    // Flush at cycle 10 of a MUL, restart at cycle 12.
    StartE = 1'b1;
    @(negedge clk);
    check("kill_busy_c0", ctl(), 64'(3'b100));
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("kill_busy_c%0d", c), ctl(), 64'(3'b110));
    end
    next_cycle();
    KillE = 1'b1;
    @(negedge clk);
    check("kill_busy_c10", ctl(), 64'(3'b010));
    next_cycle();
    KillE  = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    check("kill_busy_c11", ctl(), 64'(3'b000));
    check("kill_busy_res", {ResultHi, ResultLo}, {32'd0, 32'hFFFF_FFFE});
    check("kill_busy_nz", 64'({FlagN, FlagZ}), 64'(2'b10));
    next_cycle();
    run_mul(32'd3, 32'd4, 1'b0, 1'b0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, "restart_3x4");
    idle_hold(32'd12, 32'd0, "restart_3x4_hold");

    // Low word zero, high word nonzero: MUL only looks at the low word.
    run_mul(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'd0, 32'd0,
            1'b0, 1'b1, 1'b0, "mul_lozero");
    idle_hold(32'd0, 32'd0, "mul_lozero_hold");

    // StartE held through DONE, then a second MUL at cycle 34 (its c0 shows Busy=0).
    run_mul(32'd0, 32'h0000_1234, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, "mul_zero");
    run_mul(32'd9, 32'd9, 1'b0, 1'b0, 32'd81, 32'd0, 1'b0, 1'b0, 1'b0, "mul_b2b");
    idle_hold(32'd81, 32'd0, "mul_b2b_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
